mem_io_responder: RTL
=====================

Name: mem_io_responder

Overview:
- Memory-side responder for the 8-bit multicycle MIPS bus (memread/memwrite/adr/writedata/memdata).
- Serves a RAM region plus a small memory-mapped I/O page: GPIO, an 8-bit timer and an interrupt flag.
- Sits in the top level in place of the plain code/data memory and answers every processor bus cycle.

Parameters:
- WIDTH, 8, data and address width in bits.
- IOBASE, 8'hF0, first I/O address; RAM occupies 0 to IOBASE-1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- memread  in  1  processor read strobe.
- memwrite  in  1  processor write strobe.
- adr  in  WIDTH  byte address.
- writedata  in  WIDTH  store data.
- memdata  out  WIDTH  registered read data.
- gpio_in  in  WIDTH  asynchronous external inputs.
- gpio_out  out  WIDTH  GPIO output register.
- irq  out  1  timer interrupt request, level.

Behaviour:
- Address map:
  - 0x00 to IOBASE-1: RAM.
  - F0: GPIO_OUT, read/write.
  - F1: GPIO_IN, read-only, synchronised value.
  - F2: TCOUNT, read/write.
  - F3: TCTRL, read/write; bit0 = enable, bit1 = irq_en, other bits read 0.
  - F4: TRELOAD, read/write.
  - F5: TSTAT, bit0 = ovf; write 1 to clear.
  - F6 to FF: read 0, writes ignored.
- Reset, applied synchronously:
  - memdata, gpio_out, TCOUNT, TCTRL, TRELOAD and ovf all = 0; irq = 0.
  - The gpio_in synchroniser flops clear to 0.
  - RAM contents are not reset.
- Read path:
  - When memread = 1 at an edge, memdata takes the contents at adr.
  - Latency is one cycle: data is valid in the cycle after memread is sampled.
  - When memread = 0, memdata holds its last value.
  - Reads have no side effects.
- Write path:
  - When memwrite = 1 at an edge, writedata is stored at adr.
  - If memread and memwrite are both asserted to the same address, memdata returns the old value and the new value is stored.
- gpio_in passes through a 2-flop synchroniser; a change is visible at F1 two edges after it appears on the pins.
- Timer, evaluated each edge when enable = 1:
  - If TCOUNT = 0xFF: TCOUNT <= TRELOAD and ovf <= 1.
  - Otherwise: TCOUNT <= TCOUNT + 1, modulo 2^WIDTH.
- Timer write priority:
  - A CPU write to TCOUNT overrides the timer increment in the same cycle.
  - A write to TCOUNT while it is 0xFF does not set ovf.
  - When enable = 0, TCOUNT holds.
- ovf clear/set rules:
  - A write to F5 with writedata[0] = 1 clears ovf.
  - If an overflow occurs in the same cycle as the clear, set wins and ovf stays 1.
  - Writes with bit0 = 0 leave ovf unchanged.
- irq = ovf & irq_en, driven combinationally from registers, so it has no glitch path from the bus.
- Reset mid-operation: reset has priority over any concurrent memread, memwrite or timer event; all registers take their reset values at that edge.
- All arithmetic is unsigned WIDTH-bit; no state is wider than WIDTH except internal control bits.

Test Plan:
- RAM round trip:
  - Stimulus: reset; write 0x5A to 0x10; one cycle later memread at 0x10.
  - Required: memdata = 0x5A on the following cycle; memdata holds when memread drops.
- Read-during-write:
  - Stimulus: 0x20 holds 0x11; assert memread and memwrite together at 0x20 with writedata 0x22.
  - Required: memdata = 0x11; a subsequent read returns 0x22.
- GPIO:
  - Stimulus: write 0xC3 to F0; set gpio_in = 0x96.
  - Required: gpio_out = 0xC3 after the write edge; a read of F1 returns 0x96 only from the second edge after the input change (0x00 before).
- Timer wrap:
  - Stimulus: TRELOAD = 0xF0, TCOUNT = 0xFD, TCTRL = 0x03.
  - Required: TCOUNT steps FE, FF, F0; ovf and irq go to 1 on the wrap edge; F5 reads 0x01.
- Clear/set collision:
  - Stimulus: write 0x01 to F5 in the same cycle TCOUNT wraps.
  - Required: ovf stays 1.
  - Stimulus: a clear write on any other cycle.
  - Required: ovf = 0 and irq = 0.
- Reset mid-run:
  - Stimulus: timer running and gpio_out = 0xFF; pulse reset for 1 cycle during a memread.
  - Required: all I/O registers, memdata and irq = 0 next cycle; a previously written RAM byte still reads back intact.

Source files
------------

// File: rtl/mem_io_responder_if.sv
// Processor-side memory bus of the 8-bit multicycle MIPS core.
// The CPU drives the master modport; the memory responder answers on the slave modport.
interface mem_io_responder_if #(
  parameter int WIDTH = 8
);
  logic             memread;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;

  modport master (
    output memread,
    output memwrite,
    output adr,
    output writedata,
    input  memdata
  );

  modport slave (
    input  memread,
    input  memwrite,
    input  adr,
    input  writedata,
    output memdata
  );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder for the MIPS bus. It serves RAM below IOBASE and an I/O page above it.
// The I/O page holds GPIO, an 8-bit reloading timer and the overflow interrupt flag.
module mem_io_responder #(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] IOBASE = 8'hF0
) (
  input  logic                clk,
  input  logic                reset,
  mem_io_responder_if.slave   bus,
  input  logic [WIDTH-1:0]    gpio_in,
  output logic [WIDTH-1:0]    gpio_out,
  output logic                irq
);

  localparam int               RAM_DEPTH = int'(IOBASE);
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [WIDTH-1:0] OFF_GPO   = WIDTH'(0);
  localparam logic [WIDTH-1:0] OFF_GPI   = WIDTH'(1);
  localparam logic [WIDTH-1:0] OFF_TCNT  = WIDTH'(2);
  localparam logic [WIDTH-1:0] OFF_TCTRL = WIDTH'(3);
  localparam logic [WIDTH-1:0] OFF_TRLD  = WIDTH'(4);
  localparam logic [WIDTH-1:0] OFF_TSTAT = WIDTH'(5);

  logic [WIDTH-1:0] ram_q [RAM_DEPTH];
  logic [WIDTH-1:0] memdata_q, memdata_d;
  logic [WIDTH-1:0] gpio_out_q, gpio_out_d;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] tcount_q, tcount_d;
  logic [WIDTH-1:0] treload_q, treload_d;
  logic [1:0]       tctrl_q, tctrl_d;
  logic             ovf_q, ovf_d;

  logic             is_ram_s;
  logic [WIDTH-1:0] io_off_s;
  logic [WIDTH-1:0] rdata_s;
  logic             wr_io_s;
  logic             ovf_set_s;

  assign is_ram_s = (bus.adr < IOBASE);
  assign io_off_s = bus.adr - IOBASE;
  assign wr_io_s  = bus.memwrite && !is_ram_s;

  // Read mux over RAM and the I/O page.
  always_comb begin
    rdata_s = '0;
    if (is_ram_s) begin
      rdata_s = ram_q[bus.adr];
    end else begin
      case (io_off_s)
        OFF_GPO:   rdata_s = gpio_out_q;
        OFF_GPI:   rdata_s = sync2_q;
        OFF_TCNT:  rdata_s = tcount_q;
        OFF_TCTRL: rdata_s = {(WIDTH-2)'(0), tctrl_q};
        OFF_TRLD:  rdata_s = treload_q;
        OFF_TSTAT: rdata_s = {(WIDTH-1)'(0), ovf_q};
        default:   rdata_s = '0;
      endcase
    end
  end

  // Next-state logic: timer step first, then CPU writes take precedence.
  always_comb begin
    memdata_d  = bus.memread ? rdata_s : memdata_q;
    gpio_out_d = gpio_out_q;
    tctrl_d    = tctrl_q;
    treload_d  = treload_q;
    tcount_d   = tcount_q;
    ovf_set_s  = 1'b0;
    ovf_d      = ovf_q;
    if (tctrl_q[0]) begin
      if (tcount_q == ALL_ONES) begin
        tcount_d  = treload_q;
        ovf_set_s = 1'b1;
      end else begin
        tcount_d  = tcount_q + WIDTH'(1);
      end
    end else begin
      tcount_d = tcount_q;
    end
    if (wr_io_s) begin
      case (io_off_s)
        OFF_GPO:   gpio_out_d = bus.writedata;
        OFF_TCNT: begin
          // A CPU load replaces the wrap, so it must not raise ovf either.
          tcount_d  = bus.writedata;
          ovf_set_s = 1'b0;
        end
        OFF_TCTRL: tctrl_d   = bus.writedata[1:0];
        OFF_TRLD:  treload_d = bus.writedata;
        OFF_TSTAT: ovf_d     = bus.writedata[0] ? 1'b0 : ovf_q;
        default:   gpio_out_d = gpio_out_q;
      endcase
    end else begin
      gpio_out_d = gpio_out_q;
    end
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
  end

  // Register state; reset beats every concurrent bus or timer event.
  always_ff @(posedge clk) begin
    if (reset) begin
      memdata_q  <= '0;
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      tcount_q   <= '0;
      treload_q  <= '0;
      tctrl_q    <= 2'b00;
      ovf_q      <= 1'b0;
    end else begin
      memdata_q  <= memdata_d;
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      tcount_q   <= tcount_d;
      treload_q  <= treload_d;
      tctrl_q    <= tctrl_d;
      ovf_q      <= ovf_d;
    end
  end

  // RAM array; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && bus.memwrite && is_ram_s) begin
      ram_q[bus.adr] <= bus.writedata;
    end
  end

  assign bus.memdata = memdata_q;
  assign gpio_out    = gpio_out_q;
  assign irq         = ovf_q & tctrl_q[1];

endmodule
